// File: rtl/cpu_types_pkg.sv
// Shared CPU types and I-cache geometry.
//   word_t         : 32-bit machine word
//   ITAG_W/IIDX_W  : I-cache tag / index widths
//   IFRAMES        : number of direct-mapped I-cache frames
//   icache_frame_t : one I-cache frame {valid, tag, data}
package cpu_types_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ITAG_W  = 26;
  localparam int unsigned IIDX_W  = 4;
  localparam int unsigned IFRAMES = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

endpackage

// File: rtl/cache_control_if.sv
// Cache <-> memory controller interface.
//   cache modport: instruction read channel and data read/write channel.
interface cache_control_if;
  import cpu_types_pkg::*;

  logic  iwait;
  word_t iload;
  logic  iREN;
  word_t iaddr;

  logic  dwait;
  word_t dload;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;

  modport cache (
    input  iwait, iload, dwait, dload,
    output iREN, iaddr, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/datapath_cache_if.sv
// Datapath <-> cache interface.
//   cache modport: instruction fetch request/response, data request/response,
//   halt in, flushed out.
interface datapath_cache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  word_t imemload;
  logic  ihit;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  word_t dmemload;
  logic  dhit;

  logic  halt;
  logic  flushed;

  modport cache (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    output imemload, ihit, dmemload, dhit, flushed
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
//   CLK, nRST          : clock, synchronous active-high reset
//   imemREN, imemaddr  : fetch request from datapath
//   imemload, ihit     : fetch response (combinational)
//   iREN, iaddr        : miss request to memory (combinational)
//   iwait, iload       : memory response; miss completes when iwait is low
module icache
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output word_t imemload,
  output logic  ihit,
  input  logic  iwait,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr
);

  icache_frame_t frames [IFRAMES];

  logic [ITAG_W-1:0] tag;
  logic [IIDX_W-1:0] idx;
  icache_frame_t     rd_frame;
  icache_frame_t     wr_frame;
  logic              hit;
  logic              fill;

  // Address split; byte offset bits only travel out on iaddr.
  assign tag      = imemaddr[31:6];
  assign idx      = imemaddr[5:2];
  assign rd_frame = frames[idx];
  assign hit      = imemREN & rd_frame.valid & (rd_frame.tag == tag);
  assign fill     = imemREN & ~hit & ~iwait;
  assign wr_frame = '{valid: 1'b1, tag: tag, data: iload};

  // Response / miss request; a completing miss forwards iload the same cycle.
  always_comb begin
    imemload = '0;
    ihit     = 1'b0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (hit) begin
      imemload = rd_frame.data;
      ihit     = 1'b1;
    end else if (imemREN) begin
      iREN  = 1'b1;
      iaddr = imemaddr;
      if (!iwait) begin
        imemload = iload;
        ihit     = 1'b1;
      end
    end
  end

  // Frame storage; reset beats a same-edge fill and only clears valid bits.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      for (int unsigned i = 0; i < IFRAMES; i++) begin
        frames[IIDX_W'(i)].valid <= 1'b0;
      end
    end else if (fill) begin
      frames[idx] <= wr_frame;
    end
  end

endmodule

// File: rtl/caches.sv
// Cache wrapper: I-cache instance, pass-through D-path, flush status.
//   CPUID : core identifier, no functional effect here
//   CLK   : clock
//   nRST  : synchronous active-high reset
//   dcif  : datapath side (cache modport)
//   ccif  : memory-controller side (cache modport)
module caches #(
  parameter int unsigned CPUID = 0
) (
  input logic             CLK,
  input logic             nRST,
  datapath_cache_if.cache dcif,
  cache_control_if.cache  ccif
);

  logic flushed_q;

  icache u_icache (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (dcif.imemREN),
    .imemaddr (dcif.imemaddr),
    .imemload (dcif.imemload),
    .ihit     (dcif.ihit),
    .iwait    (ccif.iwait),
    .iload    (ccif.iload),
    .iREN     (ccif.iREN),
    .iaddr    (ccif.iaddr)
  );

  // Data side has no storage: requests go straight to memory.
  assign ccif.dREN     = dcif.dmemREN;
  assign ccif.dWEN     = dcif.dmemWEN;
  assign ccif.daddr    = dcif.dmemaddr;
  assign ccif.dstore   = dcif.dmemstore;
  assign dcif.dmemload = ccif.dload;
  assign dcif.dhit     = (dcif.dmemREN | dcif.dmemWEN) & ~ccif.dwait;

  // Nothing to write back, so flush completes on the first halted edge.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      flushed_q <= 1'b0;
    end else if (dcif.halt) begin
      flushed_q <= 1'b1;
    end
  end

  assign dcif.flushed = flushed_q;

endmodule

// File: tb/tb_caches.sv
// Scoreboard bench for caches: stimulus queues expected responses, a
// monitor pops one whenever ihit/dhit is presented.
module tb_caches;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  datapath_cache_if dcif ();
  cache_control_if  ccif ();

  caches #(.CPUID(0)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .dcif (dcif),
    .ccif (ccif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    word_t data;
    logic  iren;
  } iexp_t;

  typedef struct {
    string name;
    word_t data;
  } dexp_t;

  iexp_t iq[$];
  dexp_t dq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a presented hit must match the oldest queued expectation.
  initial begin
    iexp_t ie;
    dexp_t de;
    forever begin
      @(negedge CLK);
      if (dcif.ihit === 1'b1) begin
        if (iq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ihit_unexpected: got ihit=1 imemload=0x%08h expected no hit", dcif.imemload);
        end else begin
          ie = iq.pop_front();
          check({ie.name, "_imemload"}, dcif.imemload, ie.data);
          check({ie.name, "_iREN"}, word_t'(ccif.iREN), word_t'(ie.iren));
        end
      end
      if (dcif.dhit === 1'b1) begin
        if (dq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dhit_unexpected: got dhit=1 dmemload=0x%08h expected no hit", dcif.dmemload);
        end else begin
          de = dq.pop_front();
          check({de.name, "_dmemload"}, dcif.dmemload, de.data);
        end
      end
    end
  end

  // Expected hit: memory held in wait so a miss cannot masquerade as a hit.
  task automatic i_hit(input string name, input word_t addr, input word_t data);
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = addr;
    ccif.iwait    = 1'b1;
    ccif.iload    = 32'hFFFF_FFFF;
    iq.push_back('{name, data, 1'b1 ^ 1'b1});
    step();
  endtask

  // Expected miss: waits cycles pending, then memory returns data.
  task automatic i_miss(input string name, input word_t addr, input word_t data, input int waits);
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = addr;
    ccif.iload    = data;
    ccif.iwait    = 1'b1;
    for (int c = 0; c < waits; c++) begin
      @(negedge CLK);
      check({name, "_pend_ihit"}, word_t'(dcif.ihit), 32'd0);
      check({name, "_pend_iREN"}, word_t'(ccif.iREN), 32'd1);
      check({name, "_pend_iaddr"}, ccif.iaddr, addr);
      step();
    end
    ccif.iwait = 1'b0;
    iq.push_back('{name, data, 1'b1});
    step();
    ccif.iwait = 1'b1;
  endtask

  // One cycle of a request that must miss; no fill is allowed to complete.
  task automatic i_probe_miss(input string name, input word_t addr);
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = addr;
    ccif.iwait    = 1'b1;
    @(negedge CLK);
    check({name, "_ihit"}, word_t'(dcif.ihit), 32'd0);
    check({name, "_iREN"}, word_t'(ccif.iREN), 32'd1);
    step();
  endtask

  task automatic i_idle(input string name);
    dcif.imemREN  = 1'b0;
    dcif.imemaddr = 32'h0088_0020;
    ccif.iwait    = 1'b0;
    @(negedge CLK);
    check({name, "_ihit"}, word_t'(dcif.ihit), 32'd0);
    check({name, "_iREN"}, word_t'(ccif.iREN), 32'd0);
    check({name, "_imemload"}, dcif.imemload, 32'd0);
    step();
    ccif.iwait = 1'b1;
  endtask

  task automatic do_reset();
    dcif.imemREN = 1'b0;
    nRST         = 1'b1;
    step();
    nRST         = 1'b0;
  endtask

  initial begin
    word_t fd [16];
    word_t addr;

    nRST           = 1'b1;
    dcif.imemREN   = 1'b0;
    dcif.imemaddr  = '0;
    dcif.dmemREN   = 1'b0;
    dcif.dmemWEN   = 1'b0;
    dcif.dmemaddr  = '0;
    dcif.dmemstore = '0;
    dcif.halt      = 1'b0;
    ccif.iwait     = 1'b1;
    ccif.iload     = '0;
    ccif.dwait     = 1'b1;
    ccif.dload     = '0;

    fd[0] = 32'h0108_DDFA;
    for (int k = 1; k < 16; k++) fd[k] = 32'hA500_0000 | word_t'(k);
    fd[4]  = 32'hDEAD_DEAD;
    fd[8]  = 32'hEE00_CC00;
    fd[12] = 32'hFA10_EB08;

    step();
    step();
    nRST = 1'b0;
    @(negedge CLK);
    check("reset_flushed", word_t'(dcif.flushed), 32'd0);
    step();
    i_idle("idle_after_reset");

    // First miss with two wait cycles.
    i_miss("first_miss", 32'h0000_0000, fd[0], 2);

    // Fill the remaining indexes, alternating zero- and one-cycle waits.
    for (int k = 1; k < 16; k++) begin
      addr = word_t'(k) * 32'h0011_0004;
      i_miss($sformatf("fill_k%0d", k), addr, fd[k], k % 2);
    end

    for (int k = 0; k < 16; k++) begin
      addr = word_t'(k) * 32'h0011_0004;
      i_hit($sformatf("rehit_k%0d", k), addr, fd[k]);
    end

    // Conflict on index 0 evicts the first word.
    i_miss("conflict_fill", 32'h0044_0040, 32'hEEEE_AAAA, 1);
    i_hit("conflict_rehit", 32'h0044_0040, 32'hEEEE_AAAA);
    i_probe_miss("evicted_0", 32'h0000_0000);
    i_miss("refill_0", 32'h0000_0000, fd[0], 1);
    i_hit("after_conflict_k8", 32'h0088_0020, 32'hEE00_CC00);
    i_hit("after_conflict_k4", 32'h0044_0010, 32'hDEAD_DEAD);
    i_hit("after_conflict_k12", 32'h00CC_0030, 32'hFA10_EB08);
    i_idle("idle_mid");

    // Address moves mid-miss: only the final address is filled.
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = 32'h1234_0014;
    ccif.iload    = 32'h5A5A_0001;
    ccif.iwait    = 1'b1;
    @(negedge CLK);
    check("chg_first_iaddr", ccif.iaddr, 32'h1234_0014);
    step();
    dcif.imemaddr = 32'h5678_001C;
    @(negedge CLK);
    check("chg_second_iaddr", ccif.iaddr, 32'h5678_001C);
    check("chg_second_iREN", word_t'(ccif.iREN), 32'd1);
    step();
    ccif.iwait = 1'b0;
    iq.push_back('{"chg_fill", 32'h5A5A_0001, 1'b1});
    step();
    ccif.iwait = 1'b1;
    i_probe_miss("chg_old_addr", 32'h1234_0014);
    i_hit("chg_new_addr", 32'h5678_001C, 32'h5A5A_0001);
    i_hit("chg_idx5_intact", 32'h0055_0014, fd[5]);
    i_probe_miss("chg_idx7_evicted", 32'h0077_001C);

    // Reset on the same edge a pending miss would fill.
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = 32'h7777_0018;
    ccif.iload    = 32'hBADB_AD00;
    ccif.iwait    = 1'b1;
    @(negedge CLK);
    check("rst_miss_pend_iREN", word_t'(ccif.iREN), 32'd1);
    step();
    nRST       = 1'b1;
    ccif.iwait = 1'b0;
    iq.push_back('{"rst_edge_resp", 32'hBADB_AD00, 1'b1});
    step();
    nRST       = 1'b0;
    ccif.iwait = 1'b1;
    i_probe_miss("rst_no_fill", 32'h7777_0018);
    i_probe_miss("rst_k8_miss", 32'h0088_0020);
    i_probe_miss("rst_k6_miss", 32'h0066_0018);
    i_miss("rst_refill_k8", 32'h0088_0020, 32'hEE00_CC00, 1);
    i_hit("rst_rehit_k8", 32'h0088_0020, 32'hEE00_CC00);
    i_idle("idle_before_d");

    // Data path read.
    dcif.dmemREN  = 1'b1;
    dcif.dmemaddr = 32'h0000_0100;
    ccif.dload    = 32'h1234_5678;
    ccif.dwait    = 1'b1;
    @(negedge CLK);
    check("dread_wait_dhit", word_t'(dcif.dhit), 32'd0);
    check("dread_dREN", word_t'(ccif.dREN), 32'd1);
    check("dread_daddr", ccif.daddr, 32'h0000_0100);
    step();
    ccif.dwait = 1'b0;
    dq.push_back('{"dread", 32'h1234_5678});
    step();

    // Data path write.
    dcif.dmemREN   = 1'b0;
    dcif.dmemWEN   = 1'b1;
    dcif.dmemaddr  = 32'h0000_0204;
    dcif.dmemstore = 32'hCAFE_F00D;
    ccif.dload     = 32'h0BAD_F00D;
    ccif.dwait     = 1'b1;
    @(negedge CLK);
    check("dwrite_wait_dhit", word_t'(dcif.dhit), 32'd0);
    check("dwrite_dWEN", word_t'(ccif.dWEN), 32'd1);
    check("dwrite_dREN", word_t'(ccif.dREN), 32'd0);
    check("dwrite_dstore", ccif.dstore, 32'hCAFE_F00D);
    check("dwrite_daddr", ccif.daddr, 32'h0000_0204);
    step();
    ccif.dwait = 1'b0;
    dq.push_back('{"dwrite", 32'h0BAD_F00D});
    step();
    dcif.dmemWEN = 1'b0;
    @(negedge CLK);
    check("d_idle_dhit", word_t'(dcif.dhit), 32'd0);
    step();
    ccif.dwait = 1'b1;

    // Flush status.
    check("flushed_before_halt", word_t'(dcif.flushed), 32'd0);
    dcif.halt = 1'b1;
    @(negedge CLK);
    check("flushed_same_cycle", word_t'(dcif.flushed), 32'd0);
    step();
    check("flushed_after_edge", word_t'(dcif.flushed), 32'd1);
    dcif.halt = 1'b0;
    step();
    check("flushed_holds", word_t'(dcif.flushed), 32'd1);
    do_reset();
    check("flushed_reset", word_t'(dcif.flushed), 32'd0);

    step();
    check("iq_drained", word_t'(iq.size()), 32'd0);
    check("dq_drained", word_t'(dq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/caches.md
CACHES -- requirements
Module: caches

Interface
REQ-001 Parameter: CPUID, default 0, core identifier; carried for multicore builds, no functional effect in this block.
REQ-002 Port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Port: nRST  input  1  synchronous, active-high reset: asserted = 1, sampled on the CLK rising edge (codebase port name retained).
REQ-004 Port: dcif  interface  datapath_cache_if (cache modport)  datapath side.
- imemREN in 1; imemaddr in 32; imemload out 32; ihit out 1.
- dmemREN in 1; dmemWEN in 1; dmemaddr in 32; dmemstore in 32; dmemload out 32; dhit out 1.
- halt in 1; flushed out 1.
REQ-005 Port: ccif  interface  cache_control_if (cache modport)  memory-controller side.
- iwait in 1; iload in 32; iREN out 1; iaddr out 32.
- dwait in 1; dload in 32; dREN out 1; dWEN out 1; daddr out 32; dstore out 32.

Function
REQ-006 The I-cache SHALL be direct-mapped: 16 frames, 1 word per frame; each frame holds valid (1), tag (26), data (32).
REQ-007 Address split SHALL be: tag = imemaddr[31:6], index = imemaddr[5:2], byte offset = imemaddr[1:0] (ignored).
REQ-008 hit SHALL be combinational: imemREN & frame[index].valid & (frame[index].tag == tag).
REQ-009 On hit: imemload = frame[index].data, ihit = 1, iREN = 0; 0-cycle latency.
REQ-010 On miss (imemREN & !hit): iREN = 1, iaddr = imemaddr; while iwait = 1, ihit = 0.
REQ-011 Miss completes when iwait = 0: same cycle, imemload = iload and ihit = 1.
REQ-012 Miss fill: at that clock edge, write frame[index] = {valid 1, tag, iload}, overwriting any previous occupant.
REQ-013 The next access to the same address SHALL hit.
REQ-014 imemREN = 0: iREN = 0, ihit = 0, imemload = 0, no frame update.
REQ-015 Address change mid-miss: request follows the current imemaddr; only the address present when iwait drops is filled.
REQ-016 D-path SHALL be pass-through, no storage:
- dREN = dmemREN, dWEN = dmemWEN, daddr = dmemaddr, dstore = dmemstore, dmemload = dload.
- dhit = (dmemREN | dmemWEN) & !dwait.
REQ-017 flushed SHALL be registered: sets to 1 on the first edge with halt = 1, then holds 1 until reset.

Reset
REQ-018 When nRST = 1 at a clock edge: all 16 valid bits clear, flushed = 0.
REQ-019 Tags and data need not be cleared on reset.
REQ-020 Reset asserted during an outstanding miss SHALL abort it with no frame written; after reset, every access misses.
REQ-021 Reset SHALL take priority over a same-edge fill.
REQ-022 Outputs are combinational from inputs and state; with all valid bits clear, ihit follows only iwait/imemREN.

Structure
REQ-023 word_t (32-bit) SHALL come from cpu_types_pkg; shared constants belong in cpu_types_pkg:
- ITAG_W = 26, IIDX_W = 4, IFRAMES = 16.
- icache frame struct {valid, tag, data}.
REQ-024 The I-cache SHALL be one sub-module, icache, instantiated by caches; D-path and flushed logic live in caches.

Verification
REQ-025 Reset, then imemREN = 1, addr 0x00000000, iwait = 1 -> iREN = 1, ihit = 0; then iwait = 0, iload 0x0108DDFA -> ihit = 1, imemload 0x0108DDFA.
REQ-026 Fill all 16 indexes (addr 0x00110004·k style, e.g. 0x00880020 = 0xEE00CC00, 0x00440010 = 0xDEADDEAD, 0x00CC0030 = 0xFA10EB08) -> each re-access hits with stored data, iREN = 0.
REQ-027 Conflict miss: addr 0x00440040 (index 0, new tag 0x11001) -> miss, iREN = 1.
- Fill iload 0xEEEEAAAA -> replaces index 0.
- Then 0x00000000 -> misses.
REQ-028 After conflicts: 0x00880020 -> hit 0xEE00CC00; 0x00440010 -> hit 0xDEADDEAD; 0x00CC0030 -> hit 0xFA10EB08.
REQ-029 Assert reset after fills -> 0x00880020 misses again.
REQ-030 Reset during a pending miss -> no fill.
REQ-031 D-path and flush:
- dmemREN = 1, dwait = 1 -> dhit = 0.
- dwait = 0, dload 0x12345678 -> dhit = 1, dmemload 0x12345678.
- halt = 1 -> flushed = 1 next cycle.
